bcd_to_binary: RTL and testbench
================================

Name: bcd_to_binary

Overview:
- Sequential converter from three BCD digits (hundreds, tens, ones) to a 10-bit unsigned binary value.
- It is the inverse of the display-side binary-to-BCD path. It lets operator-entered or stored decimal setpoints (speed, distance, angle) feed the robot control logic as binary.
- Uses reverse double-dabble: one shift per cycle, with start/busy/done handshake.

Parameters:
- None. Digit count is fixed at 3 and output width at 10 bits, which covers 0..999.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- hundreds  input  4  BCD hundreds digit, valid 0..9
- tens  input  4  BCD tens digit, valid 0..9
- ones  input  4  BCD ones digit, valid 0..9
- binary  output  10  converted result (registered)
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when result/error is updated
- error  output  1  high if the last accepted request had a digit >9

Behaviour:
- Reset, synchronous and active-high:
  - state=IDLE, binary=0, busy=0, done=0, error=0.
  - Internal shift register and counter are cleared.
  - Reset asserted mid-conversion aborts it: no done pulse, and binary returns to 0.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1, capture {hundreds, tens, ones} into the 12-bit BCD field of a 22-bit work register {bcd[11:0], bin[9:0]}.
  - Clear bin=0 and counter=0, then go to SHIFT.
  - If any captured digit >9, skip SHIFT and go directly to DONE with error flagged.
- SHIFT:
  - busy=1.
  - Each cycle, shift the 22-bit work register right by 1.
  - After the shift, subtract 3 from each 4-bit BCD digit of the shifted value that is >=8.
  - Increment counter. When counter reaches 10 shifts, go to DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - Valid path: binary<=bin, error<=0.
  - Error path: binary holds its previous value, error<=1.
  - Next state is IDLE unconditionally. Start is ignored in this cycle.
- Latency:
  - Call the start-accept edge T.
  - Valid path: busy is high during cycles T+1..T+10, and done is high during cycle T+11.
  - Error path: done is high during cycle T+1, and busy is never asserted.
- binary and error hold between conversions. They change only in DONE or on reset.
- start while busy or in DONE is ignored, with no queuing. start held high continuously restarts a conversion on each return to IDLE.
- Digit inputs may change freely after the accept edge and have no effect on the running conversion.
- Arithmetic:
  - Result = 100*hundreds + 10*tens + ones, exact for all valid inputs (max 999 fits in 10 bits).
  - Subtract-3 correction never underflows because it only applies to digits >=8.

Test Plan:
- Reset, then hundreds=0, tens=4, ones=3 with a 1-cycle start pulse -> busy high for 10 cycles, done pulse at T+11, binary=43 (0x02B), error=0.
- 0,2,1 followed by 0,3,0 back-to-back, with start reasserted in the cycle after done -> binary=21, then binary=30, each with exactly one done pulse.
- 9,9,9 -> binary=999 (0x3E7). Then 0,0,0 -> binary=0. Then 2,5,5 -> binary=255.
- Load 1,2,3 (binary=123). Then apply tens=10 (0xA) -> done at T+1, error=1, busy never high, binary stays 123. Next valid request clears error.
- During SHIFT, pulse start again and change the digits -> ignored; result matches the originally captured digits.
- Assert reset at cycle T+5 of a conversion -> next cycle shows IDLE, binary=0, busy=0, no done pulse. A subsequent 5,0,7 request converts to 507.
- Exhaustive/random sweep of all 1000 valid digit triples -> binary equals 100h+10t+o every time, latency always 11 cycles.

Source files
------------

// File: rtl/bcd_to_binary.sv
// Three-digit BCD to 10-bit binary converter using reverse double-dabble,
// one right shift per cycle, with a start/busy/done handshake.
module bcd_to_binary (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [9:0] binary,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] state_dbg
);

  // Handshake: start is sampled only in IDLE; the accepting edge captures the
  // digits. busy is high for the 10 SHIFT cycles, and done pulses for exactly
  // one cycle with binary/error already holding the new result. A start seen
  // in SHIFT or DONE is dropped, not queued.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [21:0] work, work_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [9:0]  binary_nxt;
  logic        error_nxt;
  logic [21:0] shifted, corrected;
  logic        bad_digit;

  assign state_dbg = state;

  // Work register is {bcd[11:0], bin[9:0]}; after each right shift any BCD
  // digit >= 8 gets 3 removed, undoing the decimal weight of the shifted bit.
  always_comb begin
    bad_digit = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
    shifted   = work >> 1;
    corrected = shifted;
    for (int d = 0; d < 3; d++) begin
      if (shifted[10 + 4*d +: 4] >= 4'd8)
        corrected[10 + 4*d +: 4] = shifted[10 + 4*d +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_nxt  = state;
    work_nxt   = work;
    cnt_nxt    = cnt;
    binary_nxt = binary;
    error_nxt  = error;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          work_nxt = {hundreds, tens, ones, 10'd0};
          cnt_nxt  = 4'd0;
          if (bad_digit) begin
            state_nxt = DONE;
            error_nxt = 1'b1;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        work_nxt = corrected;
        cnt_nxt  = cnt + 4'd1;
        // Result is published on the edge into DONE so it is valid alongside done.
        if (cnt == 4'd9) begin
          state_nxt  = DONE;
          binary_nxt = corrected[9:0];
          error_nxt  = 1'b0;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      work   <= 22'd0;
      cnt    <= 4'd0;
      binary <= 10'd0;
      error  <= 1'b0;
    end else begin
      state  <= state_nxt;
      work   <= work_nxt;
      cnt    <= cnt_nxt;
      binary <= binary_nxt;
      error  <= error_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: handshake latency, results, error path,
// ignored start, mid-conversion reset and a full sweep of valid digit triples.
module tb_bcd_to_binary;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] hundreds, tens, ones;
  logic [9:0] binary;
  logic       busy, done, error;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  bcd_to_binary dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .binary    (binary),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; all sampling and driving happens 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from an IDLE cycle and check latency, busy length,
  // result, error flag and the single-cycle done pulse.
  task automatic run_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                          input logic [9:0] exp_bin, input logic exp_err,
                          input bit disturb, input string tag);
    int busy_cnt;
    int done_at;
    hundreds = h;
    tens     = t;
    ones     = o;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    busy_cnt = 0;
    done_at  = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_at = i;
        break;
      end
      if (disturb && i == 3) begin
        start    = 1'b1;
        hundreds = 4'd9;
        tens     = 4'd9;
        ones     = 4'd9;
      end else if (disturb && i == 4) begin
        start = 1'b0;
      end
      tick();
    end
    exp_q.push_back(exp_bin);
    chk({tag, " done_cycle"}, done_at, exp_err ? 1 : 11);
    chk({tag, " busy_cycles"}, busy_cnt, exp_err ? 0 : 10);
    chk({tag, " binary"}, binary, exp_q.pop_front());
    chk({tag, " error"}, error, exp_err);
    tick();
    chk({tag, " done_single"}, done, 1'b0);
    chk({tag, " back_to_idle"}, state_dbg, 2'd0);
  endtask

  initial begin
    int dones;
    reset    = 1'b1;
    start    = 1'b0;
    hundreds = 4'd0;
    tens     = 4'd0;
    ones     = 4'd0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset binary", binary, 10'd0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset error", error, 1'b0);
    chk("reset state", state_dbg, 2'd0);

    run_conv(4'd0, 4'd4, 4'd3, 10'd43, 1'b0, 1'b0, "c043");
    run_conv(4'd0, 4'd2, 4'd1, 10'd21, 1'b0, 1'b0, "c021");
    run_conv(4'd0, 4'd3, 4'd0, 10'd30, 1'b0, 1'b0, "c030");
    run_conv(4'd9, 4'd9, 4'd9, 10'd999, 1'b0, 1'b0, "c999");
    run_conv(4'd0, 4'd0, 4'd0, 10'd0, 1'b0, 1'b0, "c000");
    run_conv(4'd2, 4'd5, 4'd5, 10'd255, 1'b0, 1'b0, "c255");

    // Error path keeps the previous binary value.
    run_conv(4'd1, 4'd2, 4'd3, 10'd123, 1'b0, 1'b0, "c123");
    run_conv(4'd0, 4'hA, 4'd0, 10'd123, 1'b1, 1'b0, "err_tens");
    run_conv(4'hF, 4'd0, 4'd0, 10'd123, 1'b1, 1'b0, "err_hund");
    run_conv(4'd0, 4'd0, 4'd7, 10'd7, 1'b0, 1'b0, "clear_err");
    run_conv(4'd0, 4'd0, 4'hC, 10'd7, 1'b1, 1'b0, "err_ones");
    run_conv(4'd4, 4'd5, 4'd6, 10'd456, 1'b0, 1'b0, "c456");

    // Start pulse and new digits during SHIFT must not disturb the result.
    run_conv(4'd3, 4'd1, 4'd4, 10'd314, 1'b0, 1'b1, "ignore_start");

    // Reset in the middle of a conversion aborts it.
    hundreds = 4'd8;
    tens     = 4'd8;
    ones     = 4'd8;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    chk("abort pre busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort binary", binary, 10'd0);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort error", error, 1'b0);
    chk("abort state", state_dbg, 2'd0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) dones++;
      tick();
    end
    chk("abort no_activity", dones, 0);
    run_conv(4'd5, 4'd0, 4'd7, 10'd507, 1'b0, 1'b0, "c507");

    // Every valid digit triple.
    for (int h = 0; h < 10; h++) begin
      for (int t = 0; t < 10; t++) begin
        for (int o = 0; o < 10; o++) begin
          run_conv(4'(h), 4'(t), 4'(o), 10'(100*h + 10*t + o), 1'b0, 1'b0,
                   $sformatf("sweep_%0d%0d%0d", h, t, o));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
